// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for an RV32I core: fetch, decode, execute, memory, writeback.
// Define CORE_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module multicycle_controller #(
  parameter int          CNT_WIDTH      = 32,
  parameter int unsigned TRAP_ON_SYSTEM = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 stall,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 alu_src_imm,
  output logic                 trap,
`ifdef CORE_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt,
`endif
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CLS_NONE    = 4'd0,
    CLS_LUI     = 4'd1,
    CLS_AUIPC   = 4'd2,
    CLS_JAL     = 4'd3,
    CLS_JALR    = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_LOAD    = 4'd6,
    CLS_STORE   = 4'd7,
    CLS_OPIMM   = 4'd8,
    CLS_OP      = 4'd9,
    CLS_FENCE   = 4'd10,
    CLS_SYSTEM  = 4'd11,
    CLS_ILLEGAL = 4'd12
  } cls_e;

  function automatic cls_e decode_cls(input logic [6:0] op);
    case (op)
      7'b0110111: decode_cls = CLS_LUI;
      7'b0010111: decode_cls = CLS_AUIPC;
      7'b1101111: decode_cls = CLS_JAL;
      7'b1100111: decode_cls = CLS_JALR;
      7'b1100011: decode_cls = CLS_BRANCH;
      7'b0000011: decode_cls = CLS_LOAD;
      7'b0100011: decode_cls = CLS_STORE;
      7'b0010011: decode_cls = CLS_OPIMM;
      7'b0110011: decode_cls = CLS_OP;
      7'b0001111: decode_cls = CLS_FENCE;
      7'b1110011: decode_cls = CLS_SYSTEM;
      default:    decode_cls = CLS_ILLEGAL;
    endcase
  endfunction

  state_e     state_r;
  state_e     next_raw_s;
  state_e     next_state_s;
  cls_e       cls_r;
  cls_e       dec_cls_s;
  logic       stall_eff_s;
  logic       imem_req_s;
  logic       dmem_req_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       reg_write_s;
  logic       dmem_we_s;
  logic [1:0] pc_src_s;
  logic [1:0] wb_sel_s;
  logic       alu_src_imm_s;
  logic       trap_s;

  assign dec_cls_s   = decode_cls(opcode);
  // stall freezes every working state; BOOT and TRAP ignore it
  assign stall_eff_s = stall & (state_r != ST_BOOT) & (state_r != ST_TRAP);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Instruction class latched at the end of an unstalled DECODE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_r <= CLS_NONE;
    end else if ((state_r == ST_DECODE) && !stall) begin
      cls_r <= dec_cls_s;
    end else begin
      cls_r <= cls_r;
    end
  end

  // Next-state and raw (pre-stall) output decode
  always_comb begin
    next_raw_s    = state_r;
    imem_req_s    = 1'b0;
    dmem_req_s    = 1'b0;
    dmem_we_s     = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    pc_src_s      = 2'b00;
    reg_write_s   = 1'b0;
    wb_sel_s      = 2'b00;
    alu_src_imm_s = 1'b0;
    trap_s        = 1'b0;
    case (state_r)
      ST_BOOT: next_raw_s = ST_FETCH;
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ready) begin
          ir_write_s = 1'b1;
          next_raw_s = ST_DECODE;
        end else begin
          next_raw_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if ((dec_cls_s == CLS_ILLEGAL) ||
            ((dec_cls_s == CLS_SYSTEM) && (TRAP_ON_SYSTEM != 0))) begin
          next_raw_s = ST_TRAP;
        end else begin
          next_raw_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_src_imm_s = (cls_r != CLS_OP) && (cls_r != CLS_BRANCH);
        case (cls_r)
          CLS_BRANCH: begin
            pc_write_s = 1'b1;
            pc_src_s   = branch_taken ? 2'b01 : 2'b00;
            next_raw_s = ST_FETCH;
          end
          CLS_FENCE, CLS_SYSTEM: begin
            pc_write_s = 1'b1;
            next_raw_s = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: next_raw_s = ST_MEM;
          CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_OPIMM, CLS_OP: next_raw_s = ST_WB;
          default: next_raw_s = ST_BOOT;
        endcase
      end
      ST_MEM: begin
        dmem_req_s    = 1'b1;
        dmem_we_s     = (cls_r == CLS_STORE);
        alu_src_imm_s = 1'b1;
        if (dmem_ready) begin
          if (cls_r == CLS_STORE) begin
            pc_write_s = 1'b1;
            next_raw_s = ST_FETCH;
          end else begin
            next_raw_s = ST_WB;
          end
        end else begin
          next_raw_s = ST_MEM;
        end
      end
      ST_WB: begin
        reg_write_s = 1'b1;
        pc_write_s  = 1'b1;
        next_raw_s  = ST_FETCH;
        case (cls_r)
          CLS_LOAD: wb_sel_s = 2'b01;
          CLS_JAL:  begin wb_sel_s = 2'b10; pc_src_s = 2'b01; end
          CLS_JALR: begin wb_sel_s = 2'b10; pc_src_s = 2'b10; end
          default:  wb_sel_s = 2'b00;
        endcase
      end
      ST_TRAP: begin
        trap_s     = 1'b1;
        next_raw_s = ST_TRAP;
      end
      default: next_raw_s = ST_BOOT;
    endcase
  end

  assign next_state_s = stall_eff_s ? state_r : next_raw_s;

  assign imem_req    = imem_req_s  & ~stall_eff_s;
  assign dmem_req    = dmem_req_s  & ~stall_eff_s;
  assign ir_write    = ir_write_s  & ~stall_eff_s;
  assign pc_write    = pc_write_s  & ~stall_eff_s;
  assign reg_write   = reg_write_s & ~stall_eff_s;
  assign dmem_we     = dmem_we_s;
  assign pc_src      = pc_src_s;
  assign wb_sel      = wb_sel_s;
  assign alu_src_imm = alu_src_imm_s;
  assign trap        = trap_s;
  assign state_o     = state_r;

`ifdef CORE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_cnt_r;
  logic [CNT_WIDTH-1:0] instret_cnt_r;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Performance counters, frozen in BOOT and TRAP, wrapping naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_r   <= {CNT_WIDTH{1'b0}};
      instret_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if ((state_r != ST_BOOT) && (state_r != ST_TRAP)) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (pc_write) begin
        instret_cnt_r <= instret_cnt_r + CNT_ONE;
      end else begin
        instret_cnt_r <= instret_cnt_r;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_r;
  assign instret_cnt = instret_cnt_r;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: one vector per clock, expected outputs
// queued on drive and popped when the DUT outputs are sampled mid-cycle.
module tb_multicycle_controller;

  localparam logic [6:0] OP_ADD    = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       branch_taken = 1'b0;
  logic       stall = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write, alu_src_imm, trap;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] state_o;
`ifdef CORE_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
  logic [31:0] exp_cycle = 32'd0;
  logic [31:0] exp_instret = 32'd0;
`endif

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .stall(stall), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_imm(alu_src_imm),
    .trap(trap),
`ifdef CORE_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst;
    logic [6:0]  op;
    logic        bt;
    logic        stl;
    logic        ir;
    logic        dr;
    logic [14:0] ex;
  } vec_t;

  vec_t        tbl[$];
  logic [14:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  // Packing: {imem_req,dmem_req,dmem_we,ir_write,pc_write,pc_src,reg_write,wb_sel,alu,trap,state}
  function automatic logic [14:0] x(input logic [2:0] st, input logic ireq, irw, dreq, we, alu,
                                    pcw, input logic [1:0] pcs, input logic rw,
                                    input logic [1:0] wbs, input logic tr);
    return {ireq, dreq, we, irw, pcw, pcs, rw, wbs, alu, tr, st};
  endfunction

  function automatic logic [14:0] z(input logic [2:0] st);
    return x(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
  endfunction

  task automatic add(input string nm, input logic r, input logic [6:0] op, input logic bt,
                     input logic stl, input logic ir, input logic dr, input logic [14:0] ex);
    vec_t v;
    v.nm = nm; v.rst = r; v.op = op; v.bt = bt; v.stl = stl; v.ir = ir; v.dr = dr; v.ex = ex;
    tbl.push_back(v);
  endtask

  task automatic add_fetch();
    add("fetch", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0,
        x(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0));
  endtask

  initial begin
    logic [14:0] exp_v;
    logic [14:0] got_v;
    logic [14:0] exec_imm;
    logic [14:0] trap_v;
    exec_imm = x(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    trap_v   = x(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

    // ADD from reset release
    add("rst_low", 1'b0, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd0));
    add("boot", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd0));
    add_fetch();
    add("add_dec", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("add_exec", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd3));
    add("add_wb", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0,
        x(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0));
    // stall with simultaneous imem_ready, then ready re-presented
    add("fetch_stall", 1'b1, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0, z(3'd1));
    add("fetch_wait", 1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0,
        x(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0));
    add_fetch();
    // LOAD with three wait cycles
    add("ld_dec", 1'b1, OP_LOAD, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("ld_exec", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, exec_imm);
    for (int i = 0; i < 4; i++) begin
      add("ld_mem", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, (i == 3) ? 1'b1 : 1'b0,
          x(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0));
    end
    add("ld_wb", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0,
        x(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b01, 1'b0));
    // BRANCH taken / not taken
    add_fetch();
    add("br_dec", 1'b1, OP_BRANCH, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("br_exec_t", 1'b1, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0,
        x(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0));
    add_fetch();
    add("br_dec", 1'b1, OP_BRANCH, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("br_exec_nt", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0,
        x(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0));
    // STORE with stall coinciding with dmem_ready
    add_fetch();
    add("st_dec", 1'b1, OP_STORE, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("st_exec", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, exec_imm);
    add("st_mem_stall", 1'b1, 7'd0, 1'b0, 1'b1, 1'b1, 1'b1,
        x(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0));
    add("st_mem", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b1,
        x(3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0));
    // JAL and JALR
    add_fetch();
    add("jal_dec", 1'b1, OP_JAL, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("jal_exec", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, exec_imm);
    add("jal_wb", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0,
        x(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b0));
    add_fetch();
    add("jalr_dec", 1'b1, OP_JALR, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("jalr_exec", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, exec_imm);
    add("jalr_wb", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0,
        x(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0));
    // LUI with a stall in each of DECODE, EXEC, WB
    add_fetch();
    add("lui_dec_stall", 1'b1, OP_LUI, 1'b0, 1'b1, 1'b1, 1'b0, z(3'd2));
    add("lui_dec", 1'b1, OP_LUI, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("lui_exec_stall", 1'b1, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0, exec_imm);
    add("lui_exec", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, exec_imm);
    add("lui_wb_stall", 1'b1, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0, z(3'd5));
    add("lui_wb", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0,
        x(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0));
    // FENCE and OP-IMM
    add_fetch();
    add("fence_dec", 1'b1, OP_FENCE, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("fence_exec", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0,
        x(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0));
    add_fetch();
    add("opimm_dec", 1'b1, OP_OPIMM, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("opimm_exec", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, exec_imm);
    add("opimm_wb", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0,
        x(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0));
    // SYSTEM traps by default; trap is sticky and ignores stall/ready
    add_fetch();
    add("sys_dec", 1'b1, OP_SYSTEM, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    for (int i = 0; i < 20; i++) begin
      add("trap_hold", 1'b1, 7'd0, 1'b0, i[0], 1'b1, i[1], trap_v);
    end
    add("trap_rst", 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b1, z(3'd0));
    add("boot2", 1'b1, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0, z(3'd0));
    // reset mid-MEM aborts with no strobe, even with dmem_ready high
    add_fetch();
    add("ld2_dec", 1'b1, OP_LOAD, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("ld2_exec", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, exec_imm);
    add("ld2_mem", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0,
        x(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0));
    add("mem_abort", 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b1, z(3'd0));
    add("boot3", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd0));
    // illegal opcode
    add_fetch();
    add("ill_dec", 1'b1, OP_BAD, 1'b0, 1'b0, 1'b1, 1'b0, z(3'd2));
    add("ill_trap", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, trap_v);
    add("ill_trap2", 1'b1, 7'd0, 1'b0, 1'b1, 1'b1, 1'b1, trap_v);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset        = tbl[i].rst;
      opcode       = tbl[i].op;
      branch_taken = tbl[i].bt;
      stall        = tbl[i].stl;
      imem_ready   = tbl[i].ir;
      dmem_ready   = tbl[i].dr;
      exp_q.push_back(tbl[i].ex);
      #2;
      exp_v = exp_q.pop_front();
      got_v = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write, wb_sel,
               alu_src_imm, trap, state_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s vec %0d: got %b required %b", tbl[i].nm, i, got_v, exp_v);
      end
`ifdef CORE_PERF_CNT_EN
      if (!tbl[i].rst) begin
        exp_cycle   = 32'd0;
        exp_instret = 32'd0;
      end
      n_checks++;
      if ((cycle_cnt !== exp_cycle) || (instret_cnt !== exp_instret)) begin
        n_fail++;
        $display("FAIL perf_cnt vec %0d: got %0d/%0d required %0d/%0d", i,
                 cycle_cnt, instret_cnt, exp_cycle, exp_instret);
      end
      if (tbl[i].rst && (exp_v[2:0] != 3'd0) && (exp_v[2:0] != 3'd7)) exp_cycle = exp_cycle + 32'd1;
      if (exp_v[10]) exp_instret = exp_instret + 32'd1;
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences program_counter updates, instruction fetch, register_file writes and data-memory access.
- Decodes the latched instruction opcode and drives per-cycle strobes and selects.
- Handshakes with instruction and data memory through req/ready, and traps on illegal opcodes.

Parameters:
CNT_WIDTH, 32, width of optional performance counters
TRAP_ON_SYSTEM, 1, 1: SYSTEM opcode (1110011) traps; 0: SYSTEM executes as NOP

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  7  instruction[6:0] from the latched instruction register
branch_taken  input  1  branch comparator result, valid in EXEC
stall  input  1  external freeze
imem_ready  input  1  instruction word valid
dmem_ready  input  1  data access complete
imem_req  output  1  fetch request
dmem_req  output  1  data request
dmem_we  output  1  1 = store
ir_write  output  1  latch instruction register
pc_write  output  1  PC update strobe
pc_src  output  2  00 pc+4, 01 branch/jal target, 10 jalr target
reg_write  output  1  register_file write enable
wb_sel  output  2  00 ALU, 01 memory, 10 pc+4
alu_src_imm  output  1  ALU operand B = immediate
trap  output  1  sticky illegal-instruction flag
state_o  output  3  current state encoding (debug)

Behaviour:
- States and encodings:
  - BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
  - Encoding 6 is unreachable and recovers to BOOT.
- Reset:
  - reset low forces state=BOOT asynchronously and clears the class register.
  - All outputs are 0 while reset is low and while in BOOT.
  - BOOT lasts exactly one cycle, then goes to FETCH.
  - Reset asserted in any state (including mid-MEM) aborts immediately; no strobe is issued.
- Outputs:
  - State registered; outputs combinational from state, latched class and ready inputs.
  - Strobes assert in the same cycle as the ready that qualifies them.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1 for one cycle, go to DECODE.
  - Otherwise wait with no timeout.
- DECODE, 1 cycle:
  - Latch the instruction class from opcode:
    - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
    - BRANCH 1100011, LOAD 0000011, STORE 0100011
    - OPIMM 0010011, OP 0110011, FENCE 0001111, SYSTEM 1110011
  - Any other opcode, or SYSTEM with TRAP_ON_SYSTEM=1, goes to TRAP. Otherwise go to EXEC.
- EXEC:
  - alu_src_imm=1 for every class except OP and BRANCH.
  - BRANCH: pc_write=1, pc_src=01 if branch_taken else 00, go to FETCH.
  - FENCE / SYSTEM-as-NOP: pc_write=1, pc_src=00, go to FETCH.
  - LOAD/STORE: go to MEM. All other classes: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE; alu_src_imm=1.
  - Wait for dmem_ready.
  - STORE on ready: pc_write=1, pc_src=00, go to FETCH.
  - LOAD on ready: go to WB.
- WB:
  - reg_write=1 and pc_write=1, then go to FETCH.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc_src: 01 for JAL, 10 for JALR, 00 otherwise.
- TRAP:
  - trap=1; all other outputs 0.
  - Exit only by reset.
- stall:
  - When high, the state holds.
  - ir_write, pc_write, reg_write, imem_req and dmem_req are forced 0.
  - Ready inputs are ignored that cycle, including a simultaneous ready; memory must re-present ready.
  - stall has no effect in BOOT or TRAP.
- Latency with zero-wait memory:
  - BRANCH/FENCE: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - STORE: 4 cycles. LOAD: 5 cycles.

Optional Feature:
- Macro: CORE_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt [CNT_WIDTH-1:0] and instret_cnt [CNT_WIDTH-1:0], both reset to 0.
  - cycle_cnt increments every clock when not in BOOT or TRAP.
  - instret_cnt increments on every cycle where pc_write=1.
  - Both wrap modulo 2^CNT_WIDTH. Both hold during TRAP.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release with imem_ready=1, opcode=0110011 (ADD): states BOOT,FETCH,DECODE,EXEC,WB; ir_write in cycle 2; reg_write=1, wb_sel=00, pc_src=00 in cycle 5; state_o=1 in cycle 6.
- LOAD opcode 0000011 with dmem_ready delayed 3 cycles: dmem_req=1, dmem_we=0 held for 4 cycles; then WB with wb_sel=01 and reg_write=1.
- BRANCH 1100011 with branch_taken=1: pc_write=1, pc_src=01 in EXEC and reg_write never set. Repeat with branch_taken=0: pc_src=00.
- JALR 1100111: WB has wb_sel=10, pc_src=10, reg_write=1. Then opcode 1111111: state_o=7, trap=1, which persists 20 cycles until reset low.
- stall=1 in FETCH coinciding with imem_ready=1: no ir_write and state stays 1. After stall drops and ready is re-presented: ir_write=1.
- With CORE_PERF_CNT_EN: after 10 ADDs at zero wait, instret_cnt=10 and cycle_cnt=40. With CNT_WIDTH=4: wrap from 15 to 0.
